media_param: RTL and testbench
==============================

MEDIA_PARAM -- requirements
Module: media_param

Interface
REQ-001 Parameter DATA_W, default 8, sample and result width in bits (range 2..16).
REQ-002 Parameter LOG2N, default 2, log2 of samples per average; N = 2^LOG2N (range 0..5).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin or restart an averaging run.
REQ-006 mode  input  1  0 = block average, 1 = running (sliding-window) average; sampled only when start is accepted.
REQ-007 valid  input  1  data_in is captured on any rising edge where valid=1.
REQ-008 data_in  input  DATA_W  unsigned sample.
REQ-009 media  output  DATA_W  registered average result.
REQ-010 done  output  1  one-cycle pulse marking a new media value.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 count  output  LOG2N+1  number of samples in the current window.

Function
REQ-013 The FSM SHALL have states IDLE, ACC and DONE.
REQ-014 In IDLE, start=1 SHALL clear the accumulator, count and window buffer, latch mode, and enter ACC.
REQ-015 In IDLE, valid SHALL be ignored; a valid arriving in the same cycle as start SHALL be discarded.
REQ-016 In ACC, each valid=1 edge SHALL add data_in to an accumulator of width DATA_W+LOG2N; this width SHALL never overflow.
REQ-017 Block mode: the edge capturing the Nth sample SHALL move the FSM to DONE.
REQ-018 DONE SHALL register media = acc >> LOG2N, assert done for exactly one cycle, then return to IDLE.
REQ-019 Running mode: the FSM SHALL stay in ACC. Each sample SHALL be written to an N-entry circular buffer, and sum SHALL be updated as sum + new - oldest.
REQ-020 Running mode: once count = N, every subsequent valid SHALL update media and pulse done on the following cycle.
REQ-021 Running mode: count SHALL saturate at N, and the buffer write pointer SHALL wrap from N-1 to 0.
REQ-022 start=1 in ACC or DONE SHALL restart as in REQ-014; a valid in the same cycle SHALL be discarded, and a pending done SHALL be suppressed.
REQ-023 media SHALL hold its last value until the next result.
REQ-024 The block SHALL accept valid on consecutive cycles with no stall.
REQ-025 When LOG2N=0, every sample SHALL be its own result, with media = data_in one cycle after capture.

Reset
REQ-026 reset SHALL force the state to IDLE and set media=0, done=0, busy=0, count=0 and accumulator=0, independent of clk.
REQ-027 Reset asserted mid-run SHALL discard partial sums; the buffer contents need not be cleared but SHALL NOT be used before being rewritten.

Configuration
REQ-028 With MEDIA_ROUND_EN defined, media SHALL equal (acc + 2^(LOG2N-1)) >> LOG2N (round half up), with no overflow possible; when LOG2N=0 the result is unchanged.
REQ-029 Without MEDIA_ROUND_EN, media SHALL equal acc >> LOG2N (truncation).

Structure
REQ-030 Package media_pkg SHALL hold the FSM state type, the mode encodings, and the DATA_W/LOG2N range limits.
REQ-031 The circular window buffer SHALL be the sub-module media_window_buf: N x DATA_W, with write pointer and oldest-entry read.

Verification
REQ-032 Block mode, defaults: start, then samples 24, 32, 10, 14 -> media=20 with done high for one cycle, followed by IDLE and busy=0.
REQ-033 Block mode: samples 1, 2, 2, 2 -> media=1 without MEDIA_ROUND_EN, and media=2 with it.
REQ-034 Running mode, LOG2N=2: samples 4, 8, 12, 16, 20 -> no done for the first 3 samples; media=10 after the 4th, then 14 after the 5th; count holds at 4.
REQ-035 After 2 samples, start=1 with valid=1 in the same cycle -> that sample is discarded and count=0; samples 8, 8, 8, 8 then give media=8.
REQ-036 Reset asserted after 3 samples -> all outputs read 0; a new run of 0, 0, 0, 4 gives media=1.
REQ-037 DATA_W=12, LOG2N=3: eight samples of 4095 on consecutive cycles -> media=4095 with no overflow.

Source files
------------

// File: rtl/media_pkg.sv
// Shared FSM state encodings, mode codes and parameter range limits for media_param.
package media_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACC  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic MODE_BLOCK = 1'b0;
  localparam logic MODE_RUN   = 1'b1;

  localparam int DATA_W_MIN = 2;
  localparam int DATA_W_MAX = 16;
  localparam int LOG2N_MIN  = 0;
  localparam int LOG2N_MAX  = 5;
endpackage

// File: rtl/media_window_buf.sv
// N-entry circular sample window; read port always shows the oldest entry (the one the next write replaces).
// Latency: write visible on the next cycle. Backpressure: none, accepts a write every cycle.
module media_window_buf #(
  parameter int DATA_W = 8,
  parameter int LOG2N  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] oldest
);
  import media_pkg::*;

  localparam int PTR_W = (LOG2N > 0) ? LOG2N : 1;
  // Equals N, except N=1 where a spare entry keeps the 1-bit pointer in range.
  localparam int DEPTH = 1 << PTR_W;

  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= (wr_ptr == PTR_W'((1 << LOG2N) - 1)) ? '0 : wr_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign oldest = mem[wr_ptr];
endmodule

// File: rtl/media_param.sv
// Block / sliding-window averager of 2^LOG2N samples; MEDIA_ROUND_EN selects round-half-up instead of truncation.
// Latency: media and done update one cycle after the completing sample. Backpressure: none, valid every cycle.
module media_param #(
  parameter int DATA_W = 8,
  parameter int LOG2N  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] media,
  output logic              done,
  output logic              busy,
  output logic [LOG2N:0]    count
);
  import media_pkg::*;

  localparam int N     = 1 << LOG2N;
  localparam int ACC_W = DATA_W + LOG2N;
  localparam int CNT_W = LOG2N + 1;

  state_t            state;
  logic              run_mode;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] oldest;
  logic [DATA_W-1:0] oldest_used;
  logic [ACC_W:0]    rnd;
  logic [DATA_W-1:0] result;
  logic              full;
  logic              take;
  logic              hit;

  // A valid coinciding with start is dropped: start always wins.
  assign take = (state == ST_ACC) && valid && !start;
  assign full = (count_q == CNT_W'(N));

  media_window_buf #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .wr_en   (take && (run_mode == MODE_RUN)),
    .wr_data (data_in),
    .oldest  (oldest)
  );

  // Until the window fills, the oldest slot holds nothing to subtract; this also hides stale data left by reset.
  always_comb begin
    oldest_used = '0;
    if ((run_mode == MODE_RUN) && full) oldest_used = oldest;
    acc_nxt = acc + ACC_W'(data_in) - ACC_W'(oldest_used);
    cnt_nxt = full ? count_q : count_q + CNT_W'(1);
  end

  assign hit = (cnt_nxt == CNT_W'(N));

`ifdef MEDIA_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(N / 2);
  assign rnd = {1'b0, acc_nxt} + HALF;
`else
  assign rnd = {1'b0, acc_nxt};
`endif
  assign result = DATA_W'(rnd >> LOG2N);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      run_mode <= MODE_BLOCK;
      acc      <= '0;
      count_q  <= '0;
      media    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= ST_ACC;
        run_mode <= mode;
        acc      <= '0;
        count_q  <= '0;
      end else begin
        case (state)
          ST_ACC: begin
            if (take) begin
              acc     <= acc_nxt;
              count_q <= cnt_nxt;
              if (hit) begin
                media <= result;
                done  <= 1'b1;
                if (run_mode == MODE_BLOCK) state <= ST_DONE;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy  = (state != ST_IDLE);
  assign count = count_q;
endmodule

// File: tb/tb_media_param.sv
// Directed-vector bench for media_param: defaults, DATA_W=12/LOG2N=3 and LOG2N=0 instances share one stimulus bus.
module tb_media_param;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] din = '0;

  logic [7:0]  media_a;
  logic        done_a, busy_a;
  logic [2:0]  count_a;
  logic [11:0] media_b;
  logic        done_b, busy_b;
  logic [3:0]  count_b;
  logic [7:0]  media_c;
  logic        done_c, busy_c;
  logic [0:0]  count_c;

  int n_chk = 0;
  int n_err = 0;

  media_param #(.DATA_W(8), .LOG2N(2)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .valid(valid),
    .data_in(din[7:0]), .media(media_a), .done(done_a), .busy(busy_a), .count(count_a)
  );

  media_param #(.DATA_W(12), .LOG2N(3)) dut_w12 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .valid(valid),
    .data_in(din[11:0]), .media(media_b), .done(done_b), .busy(busy_b), .count(count_b)
  );

  media_param #(.DATA_W(8), .LOG2N(0)) dut_n1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .valid(valid),
    .data_in(din[7:0]), .media(media_c), .done(done_c), .busy(busy_c), .count(count_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic go(input logic m);
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    din   = d;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  int exp_r;

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_media", media_a, 0);
    check("rst_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_count", count_a, 0);
    reset = 1'b0;

    // valid in IDLE must be ignored
    send(16'd77);
    check("idle_count", count_a, 0);
    check("idle_busy", busy_a, 0);

    // block average 24,32,10,14 -> 20
    go(1'b0);
    check("blk_busy", busy_a, 1);
    send(16'd24); send(16'd32); send(16'd10);
    check("blk_nodone3", done_a, 0);
    send(16'd14);
    check("blk_done", done_a, 1);
    check("blk_media", media_a, 20);
    check("blk_count", count_a, 4);
    @(posedge clk); #1;
    check("blk_done_1cyc", done_a, 0);
    check("blk_idle_busy", busy_a, 0);
    check("blk_media_hold", media_a, 20);

    // 1,2,2,2: sum 7 -> 1 truncated, 2 rounded
`ifdef MEDIA_ROUND_EN
    exp_r = 2;
`else
    exp_r = 1;
`endif
    go(1'b0);
    send(16'd1); send(16'd2); send(16'd2); send(16'd2);
    check("rnd_media", media_a, exp_r);

    // running average 4,8,12,16,20
    go(1'b1);
    send(16'd4);
    check("run_nodone1", done_a, 0);
    send(16'd8);
    check("run_nodone2", done_a, 0);
    send(16'd12);
    check("run_nodone3", done_a, 0);
    check("run_count3", count_a, 3);
    send(16'd16);
    check("run_done4", done_a, 1);
    check("run_media4", media_a, 10);
    check("run_count4", count_a, 4);
    send(16'd20);
    check("run_done5", done_a, 1);
    check("run_media5", media_a, 14);
    check("run_count_sat", count_a, 4);
    @(posedge clk); #1;
    check("run_done_clr", done_a, 0);
    check("run_busy", busy_a, 1);

    // restart mid-run with a colliding valid
    go(1'b0);
    send(16'd5); send(16'd6);
    din = 16'd99; valid = 1'b1; start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b0;
    check("rst_mid_count", count_a, 0);
    check("rst_mid_done", done_a, 0);
    check("rst_mid_media_hold", media_a, 14);
    send(16'd8); send(16'd8); send(16'd8);
    check("restart_nodone3", done_a, 0);
    send(16'd8);
    check("restart_done", done_a, 1);
    check("restart_media", media_a, 8);

    // asynchronous reset mid-run, then buffer stale data must not leak
    go(1'b1);
    send(16'd50); send(16'd60); send(16'd70);
    reset = 1'b1;
    #2;
    check("areset_media", media_a, 0);
    check("areset_done", done_a, 0);
    check("areset_busy", busy_a, 0);
    check("areset_count", count_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    go(1'b1);
    send(16'd0); send(16'd0); send(16'd0); send(16'd4);
    check("post_rst_done", done_a, 1);
    check("post_rst_media", media_a, 1);
    send(16'd4);
    check("post_rst_media2", media_a, 2);

    // DATA_W=12, LOG2N=3: eight back-to-back full-scale samples
    go(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("w12_nodone7", done_b, 0);
      send(16'd4095);
    end
    check("w12_done", done_b, 1);
    check("w12_media", media_b, 4095);

    // LOG2N=0 running mode: every sample is its own result
    go(1'b1);
    send(16'd7);
    check("n1_done", done_c, 1);
    check("n1_media", media_c, 7);
    send(16'd200);
    check("n1_media2", media_c, 200);
    check("n1_count", count_c, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
